code_lock_param: RTL and testbench
==================================

// Module: code_lock_param
// PURPOSE
//  Parametrised sequential code lock: the user enters digits on numero, strobed by insere.
//  Code length, error tolerance, lockout time and the stored code are all configurable.
//  While unlocked, the code can be reprogrammed. Drives a status LED, open/lockout flags and an active-low 7-segment display.
// PARAMETERS
//  DIGIT_W      4          bits per digit (display decode is defined for 4 only)
//  CODE_LEN     6          digits per code, >=2
//  MAX_ERRORS   1          wrong digits tolerated; the (MAX_ERRORS+1)th wrong digit locks out
//  LOCKOUT_CYC  0          lockout duration in clk cycles; 0 = locked until reset
//  DEFAULT_CODE 24'h590981 reset code; first digit in the MSBs, width DIGIT_W*CODE_LEN
// PORTS
//  clk        in   1                   single clock, rising edge
//  reset      in   1                   synchronous, active-high
//  insere     in   1                   digit strobe (level); one accept per rising edge
//  prog       in   1                   request reprogramming; sampled on accept in OPEN
//  numero     in   [DIGIT_W:1]         digit value
//  LED        out  1                   1 = at least one wrong digit this attempt
//  aberto     out  1                   1 = unlocked (OPEN)
//  bloqueado  out  1                   1 = lockout (LOCKED)
//  err_cnt    out  $clog2(MAX_ERRORS+2) wrong digits this attempt
//  A,B,C,D,E,F,G out 1 each            segments, active-low (0 = lit)
// BEHAVIOUR
//  - Reset: state ENTRY, idx=0, code reg=DEFAULT_CODE, err_cnt=0, LED/aberto/bloqueado=0,
//    segments all 1 (blank), insere_q=0, lockout counter=0. Reset beats every other event.
//  - accept = insere & ~insere_q (insere_q registered). A held strobe gives one accept.
//  - All outputs are registered. The effect of an accept is visible the cycle after the accepting edge.
//  - ENTRY:
//    - On accept with numero==code[idx]: idx++. A match on idx==CODE_LEN-1 -> OPEN.
//    - On accept with a mismatch: err_cnt++ and idx is held (the same digit is retried).
//      If the new err_cnt > MAX_ERRORS -> LOCKED; load the counter with LOCKOUT_CYC.
//  - LED = (err_cnt!=0). It is cleared only by reset or by a return to ENTRY from OPEN, PROG or LOCKED.
//  - OPEN:
//    - Accept with prog=1 -> PROG, idx=0.
//    - Accept with prog=0 -> ENTRY, idx=0, err_cnt=0 (relock).
//  - PROG: each accept writes numero into code slot idx, then idx++. The write at idx==CODE_LEN-1
//    -> ENTRY, idx=0, err_cnt=0. The new code is effective immediately.
//  - LOCKED:
//    - LOCKOUT_CYC==0: stay until reset. Otherwise decrement each cycle.
//    - When the counter reaches 1 -> ENTRY, idx=0, err_cnt=0. Accepts during LOCKED are ignored,
//      including one on the exit cycle.
//  - Reset mid-PROG aborts programming; the code reverts to DEFAULT_CODE.
//  - Display (registered) for {A..G}:
//    - ENTRY/PROG: hex decode of live numero (0-F).
//    - OPEN: "S" 0100100 if err_cnt==0, else "P" 0011000.
//    - LOCKED: "F" 0111000.
//  - Widths: idx $clog2(CODE_LEN); err_cnt saturates at MAX_ERRORS+1; lockout counter $clog2(LOCKOUT_CYC+1).
// STRUCTURE
//  - Shared package code_lock_pkg:
//    - state encoding ENTRY/OPEN/PROG/LOCKED;
//    - SEG_S, SEG_P, SEG_F, SEG_BLANK constants;
//    - digit-slot index helper for the packed code register.
//  - One sub-module hex7seg_dec: combinational 4-bit -> 7-bit active-low hex decoder.
//  - The top level holds the FSM, code register, error and lockout counters, and output registers.
// TESTING
//  1. Reset; enter 5,9,0,9,8,1 -> aberto=1, LED=0, err_cnt=0, {A..G}=0100100.
//  2. Enter 5,9,3,0,9,8,1 -> LED=1 after the 3; ends with aberto=1, err_cnt=1, {A..G}=0011000.
//  3. LOCKOUT_CYC=16; enter 5,7,9,2 -> bloqueado=1, {A..G}=0111000. After 16 cycles: ENTRY, LED=0, err_cnt=0.
//  4. Open with the default code; prog=1 + accept, then 1,2,3,4,5,6 -> code 590981 now fails;
//     123456 opens.
//  5. Hold insere high 10 cycles with numero=5 -> idx advances once. Reset mid-PROG -> 590981 opens again.
//  6. Accept on the lockout exit cycle -> ignored, idx=0. Accept while LOCKOUT_CYC=0 -> still locked.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types and constants for the parametrised code lock.
package code_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_OPEN,
    ST_PROG,
    ST_LOCKED
  } state_t;

  // Active-low segment patterns, bit order {A,B,C,D,E,F,G}
  localparam logic [6:0] SEG_S     = 7'b0100100;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // LSB position of digit slot idx; slot 0 occupies the MSBs of the code register
  function automatic int unsigned slot_lsb(input int unsigned idx,
                                           input int unsigned code_len,
                                           input int unsigned digit_w);
    return (code_len - 1 - idx) * digit_w;
  endfunction

endpackage

// File: rtl/code_lock_param_hex7seg_dec.sv
// Combinational 4-bit to active-low 7-segment hex decoder, output {A,B,C,D,E,F,G}.
module hex7seg_dec (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_hex)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/code_lock_param.sv
// Parametrised sequential code lock with reprogrammable code, error tolerance,
// timed or permanent lockout, and a registered active-low 7-segment display.
module code_lock_param
  import code_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned CODE_LEN    = 6,
  parameter int unsigned MAX_ERRORS  = 1,
  parameter int unsigned LOCKOUT_CYC = 0,
  parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 24'h590981
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  insere,
  input  logic                                  prog,
  input  logic [DIGIT_W:1]                      numero,
  output logic                                  LED,
  output logic                                  aberto,
  output logic                                  bloqueado,
  output logic [$clog2(MAX_ERRORS+2)-1:0]       err_cnt,
  output logic                                  A,
  output logic                                  B,
  output logic                                  C,
  output logic                                  D,
  output logic                                  E,
  output logic                                  F,
  output logic                                  G
);

  localparam int unsigned IDX_W  = $clog2(CODE_LEN);
  localparam int unsigned ERR_W  = $clog2(MAX_ERRORS + 2);
  localparam int unsigned CNT_W  = (LOCKOUT_CYC == 0) ? 1 : $clog2(LOCKOUT_CYC + 1);
  localparam int unsigned CODE_W = DIGIT_W * CODE_LEN;

  state_t              r_state, w_state_n;
  logic [IDX_W-1:0]    r_idx, w_idx_n;
  logic [CODE_W-1:0]   r_code, w_code_n;
  logic [ERR_W-1:0]    r_err, w_err_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                r_insere_q;
  logic                r_led, r_aberto, r_bloq;
  logic [6:0]          r_seg, w_seg_n;
  logic                w_accept;
  logic [DIGIT_W-1:0]  w_cur_digit;
  logic [3:0]          w_hex_in;
  logic [6:0]          w_hex_seg;

  assign w_accept = insere & ~r_insere_q;
  assign w_hex_in = 4'(numero);

  hex7seg_dec u_hex (
    .i_hex (w_hex_in),
    .o_seg (w_hex_seg)
  );

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_code_n    = r_code;
    w_err_n     = r_err;
    w_cnt_n     = r_cnt;
    w_seg_n     = SEG_BLANK;
    w_cur_digit = r_code[slot_lsb(int'(r_idx), CODE_LEN, DIGIT_W) +: DIGIT_W];

    case (r_state)
      ST_ENTRY: begin
        if (w_accept) begin
          if (numero == w_cur_digit) begin
            if (r_idx == IDX_W'(CODE_LEN - 1)) begin
              w_state_n = ST_OPEN;
              w_idx_n   = '0;
            end else begin
              w_idx_n = r_idx + 1'b1;
            end
          end else begin
            // r_err never exceeds MAX_ERRORS while in ENTRY, so +1 cannot pass saturation
            w_err_n = r_err + 1'b1;
            if (r_err >= ERR_W'(MAX_ERRORS)) begin
              w_state_n = ST_LOCKED;
              w_cnt_n   = CNT_W'(LOCKOUT_CYC);
            end
          end
        end
      end
      ST_OPEN: begin
        if (w_accept) begin
          w_idx_n = '0;
          if (prog) begin
            w_state_n = ST_PROG;
          end else begin
            w_state_n = ST_ENTRY;
            w_err_n   = '0;
          end
        end
      end
      ST_PROG: begin
        if (w_accept) begin
          w_code_n[slot_lsb(int'(r_idx), CODE_LEN, DIGIT_W) +: DIGIT_W] = numero;
          if (r_idx == IDX_W'(CODE_LEN - 1)) begin
            w_state_n = ST_ENTRY;
            w_idx_n   = '0;
            w_err_n   = '0;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (LOCKOUT_CYC != 0) begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_n = ST_ENTRY;
            w_idx_n   = '0;
            w_err_n   = '0;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      end
      default: w_state_n = ST_ENTRY;
    endcase

    case (w_state_n)
      ST_ENTRY, ST_PROG: w_seg_n = w_hex_seg;
      ST_OPEN:           w_seg_n = (w_err_n == '0) ? SEG_S : SEG_P;
      ST_LOCKED:         w_seg_n = SEG_F;
      default:           w_seg_n = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ENTRY;
      r_idx      <= '0;
      r_code     <= DEFAULT_CODE;
      r_err      <= '0;
      r_cnt      <= '0;
      r_insere_q <= 1'b0;
      r_led      <= 1'b0;
      r_aberto   <= 1'b0;
      r_bloq     <= 1'b0;
      r_seg      <= SEG_BLANK;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_code     <= w_code_n;
      r_err      <= w_err_n;
      r_cnt      <= w_cnt_n;
      r_insere_q <= insere;
      r_led      <= (w_err_n != '0);
      r_aberto   <= (w_state_n == ST_OPEN);
      r_bloq     <= (w_state_n == ST_LOCKED);
      r_seg      <= w_seg_n;
    end
  end

  assign LED       = r_led;
  assign aberto    = r_aberto;
  assign bloqueado = r_bloq;
  assign err_cnt   = r_err;
  assign {A, B, C, D, E, F, G} = r_seg;

endmodule

// File: tb/tb_code_lock_param.sv
// Directed bench: a permanent-lockout lock and a 16-cycle-lockout lock share one stimulus stream.
module tb_code_lock_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       insere = 1'b0;
  logic       prog = 1'b0;
  logic [4:1] numero = 4'h0;

  logic       led0, ab0, bl0, a0, b0, c0, d0, e0, f0, g0;
  logic       led1, ab1, bl1, a1, b1, c1, d1, e1, f1, g1;
  logic [1:0] err0, err1;
  logic [6:0] seg0, seg1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  code_lock_param u_dut0 (
    .clk(clk), .reset(reset), .insere(insere), .prog(prog), .numero(numero),
    .LED(led0), .aberto(ab0), .bloqueado(bl0), .err_cnt(err0),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0)
  );

  code_lock_param #(.LOCKOUT_CYC(16)) u_dut1 (
    .clk(clk), .reset(reset), .insere(insere), .prog(prog), .numero(numero),
    .LED(led1), .aberto(ab1), .bloqueado(bl1), .err_cnt(err1),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1)
  );

  assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
  assign seg1 = {a1, b1, c1, d1, e1, f1, g1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; insere = 1'b0; prog = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One accept: strobe high across one rising edge, return at the next falling edge
  task automatic key(input logic [3:0] d, input logic p);
    @(negedge clk);
    numero = d; prog = p; insere = 1'b1;
    @(negedge clk);
    insere = 1'b0; prog = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [3:0] def_code [6];
    logic [3:0] new_code [6];
    def_code = '{4'h5, 4'h9, 4'h0, 4'h9, 4'h8, 4'h1};
    new_code = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

    // Test 1: reset state and default code
    do_reset();
    chk("rst_aberto", 32'(ab0), 32'd0);
    chk("rst_bloq", 32'(bl0), 32'd0);
    chk("rst_led", 32'(led0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_seg", 32'(seg0), 32'h7F);
    for (int i = 0; i < 6; i++) key(def_code[i], 1'b0);
    chk("t1_aberto0", 32'(ab0), 32'd1);
    chk("t1_aberto1", 32'(ab1), 32'd1);
    chk("t1_led", 32'(led0), 32'd0);
    chk("t1_err", 32'(err0), 32'd0);
    chk("t1_seg_S", 32'(seg0), 32'h24);

    // Test 2: one tolerated error
    key(4'h0, 1'b0);
    chk("t2_relock", 32'(ab0), 32'd0);
    chk("t2_entry_seg0", 32'(seg0), 32'h01);
    key(4'h5, 1'b0); key(4'h9, 1'b0);
    chk("t2_led_pre", 32'(led0), 32'd0);
    key(4'h3, 1'b0);
    chk("t2_led_after3", 32'(led0), 32'd1);
    chk("t2_err_after3", 32'(err0), 32'd1);
    key(4'h0, 1'b0); key(4'h9, 1'b0); key(4'h8, 1'b0); key(4'h1, 1'b0);
    chk("t2_aberto", 32'(ab0), 32'd1);
    chk("t2_err", 32'(err0), 32'd1);
    chk("t2_seg_P", 32'(seg1), 32'h18);
    key(4'h0, 1'b0);
    chk("t2_led_cleared", 32'(led0), 32'd0);

    // Test 3: second error locks; timed lockout on dut1
    key(4'h5, 1'b0); key(4'h7, 1'b0);
    chk("t3_led", 32'(led1), 32'd1);
    key(4'h9, 1'b0); key(4'h2, 1'b0);
    chk("t3_bloq1", 32'(bl1), 32'd1);
    chk("t3_bloq0", 32'(bl0), 32'd1);
    chk("t3_seg_F", 32'(seg1), 32'h38);
    chk("t3_err_sat", 32'(err1), 32'd2);
    idle(15);
    chk("t3_still_locked", 32'(bl1), 32'd1);
    idle(1);
    chk("t3_released", 32'(bl1), 32'd0);
    chk("t3_led_clr", 32'(led1), 32'd0);
    chk("t3_err_clr", 32'(err1), 32'd0);
    chk("t3_dut0_locked", 32'(bl0), 32'd1);

    // Test 4: reprogram to 123456
    do_reset();
    for (int i = 0; i < 6; i++) key(def_code[i], 1'b0);
    key(4'h0, 1'b1);
    chk("t4_prog_not_open", 32'(ab0), 32'd0);
    for (int i = 0; i < 6; i++) key(new_code[i], 1'b0);
    key(4'h5, 1'b0);
    chk("t4_old_fails_led", 32'(led0), 32'd1);
    chk("t4_old_fails_err", 32'(err0), 32'd1);
    for (int i = 0; i < 6; i++) key(new_code[i], 1'b0);
    chk("t4_new_opens", 32'(ab0), 32'd1);
    chk("t4_seg_P", 32'(seg0), 32'h18);

    // Test 5: held strobe gives one accept; reset mid-PROG restores default
    do_reset();
    @(negedge clk);
    numero = 4'h5; insere = 1'b1;
    idle(10);
    insere = 1'b0;
    for (int i = 1; i < 6; i++) key(def_code[i], 1'b0);
    chk("t5_held_opens", 32'(ab0), 32'd1);
    chk("t5_held_err", 32'(err0), 32'd0);
    key(4'h0, 1'b1);
    key(4'h1, 1'b0); key(4'h2, 1'b0); key(4'h3, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) key(def_code[i], 1'b0);
    chk("t5_default_back", 32'(ab0), 32'd1);
    chk("t5_default_err", 32'(err0), 32'd0);

    // Test 6: accept on lockout exit edge is ignored; permanent lockout ignores accepts
    key(4'h0, 1'b0);
    key(4'h5, 1'b0); key(4'h0, 1'b0); key(4'h0, 1'b0);
    chk("t6_locked1", 32'(bl1), 32'd1);
    idle(15);
    numero = 4'h5; insere = 1'b1;
    @(negedge clk);
    insere = 1'b0;
    chk("t6_exit", 32'(bl1), 32'd0);
    chk("t6_exit_err", 32'(err1), 32'd0);
    chk("t6_exit_seg5", 32'(seg1), 32'h24);
    chk("t6_dut0_locked", 32'(bl0), 32'd1);
    chk("t6_dut0_segF", 32'(seg0), 32'h38);
    for (int i = 0; i < 6; i++) key(def_code[i], 1'b0);
    chk("t6_idx0_opens", 32'(ab1), 32'd1);
    chk("t6_idx0_err", 32'(err1), 32'd0);
    chk("t6_dut0_still", 32'(bl0), 32'd1);
    chk("t6_dut0_closed", 32'(ab0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
